// File: rtl/crypt_wb_port.sv
// crypt_wb_port: MPRF-side responder for the crypt engine. Reads are served combinationally.
// Writes either pass straight through or wait in an in-order buffer while the EXU owns the
// MPRF write port. Define CRYPT_WB_FWD_EN to forward pending writes to reads; otherwise the
// port raises port2idu_hazard.
module crypt_wb_port #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  crypt2mprf_rs1_addr,
    input  logic [4:0]  crypt2mprf_rs2_addr,
    output logic [31:0] mprf2crypt_rs1_data,
    output logic [31:0] mprf2crypt_rs2_data,
    input  logic        crypt2mprf_wreq,
    input  logic [4:0]  crypt2mprf_rd_addr,
    input  logic [31:0] crypt2mprf_rd_data,
    output logic [4:0]  port2mprf_rs1_addr,
    output logic [4:0]  port2mprf_rs2_addr,
    input  logic [31:0] mprf2port_rs1_data,
    input  logic [31:0] mprf2port_rs2_data,
    input  logic        exu2port_wbusy,
    output logic        port2mprf_wreq,
    output logic [4:0]  port2mprf_rd_addr,
    output logic [31:0] port2mprf_rd_data,
    output logic        port2idu_wb_full,
    output logic        port2idu_hazard,
    output logic        port2csr_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          accept, drain, cut, enq, drop, full;

    assign full   = count == CW'(DEPTH);
    assign accept = crypt2mprf_wreq && crypt2mprf_rd_addr != 5'd0;
    assign drain  = count != '0 && !exu2port_wbusy;
    assign cut    = count == '0 && !exu2port_wbusy && accept;
    assign enq    = accept && !cut && (!full || drain);
    assign drop   = accept && full && !drain;

    assign port2mprf_rs1_addr = crypt2mprf_rs1_addr;
    assign port2mprf_rs2_addr = crypt2mprf_rs2_addr;
    assign port2mprf_wreq     = rst_n && (drain || cut);
    assign port2mprf_rd_addr  = drain ? mem_addr[rd_ptr] : crypt2mprf_rd_addr;
    assign port2mprf_rd_data  = drain ? mem_data[rd_ptr] : crypt2mprf_rd_data;
    assign port2idu_wb_full   = full;

    // Pointer, occupancy and sticky overflow bookkeeping; a reset discards pending entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            port2csr_overflow <= 1'b0;
        end else begin
            wr_ptr            <= enq ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr            <= drain ? rd_ptr + 1'b1 : rd_ptr;
            count             <= count + CW'(enq) - CW'(drain);
            port2csr_overflow <= port2csr_overflow || drop;
        end
    end

    // Entry storage carries no reset; validity comes only from count and rd_ptr.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr[wr_ptr] <= crypt2mprf_rd_addr;
            mem_data[wr_ptr] <= crypt2mprf_rd_data;
        end
    end

`ifdef CRYPT_WB_FWD_EN
    logic [31:0] fwd1, fwd2;

    // Walk pending entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd1 = mprf2port_rs1_data;
        fwd2 = mprf2port_rs2_data;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                if (mem_addr[rd_ptr + PW'(k)] == crypt2mprf_rs1_addr) fwd1 = mem_data[rd_ptr + PW'(k)];
                if (mem_addr[rd_ptr + PW'(k)] == crypt2mprf_rs2_addr) fwd2 = mem_data[rd_ptr + PW'(k)];
            end
        end
    end

    assign mprf2crypt_rs1_data = crypt2mprf_rs1_addr == 5'd0 ? 32'd0 : fwd1;
    assign mprf2crypt_rs2_data = crypt2mprf_rs2_addr == 5'd0 ? 32'd0 : fwd2;
    assign port2idu_hazard     = 1'b0;
`else
    logic hit1, hit2;

    // Flag any read address that matches a pending entry so the IDU can stall.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                if (mem_addr[rd_ptr + PW'(k)] == crypt2mprf_rs1_addr) hit1 = 1'b1;
                if (mem_addr[rd_ptr + PW'(k)] == crypt2mprf_rs2_addr) hit2 = 1'b1;
            end
        end
    end

    assign mprf2crypt_rs1_data = crypt2mprf_rs1_addr == 5'd0 ? 32'd0 : mprf2port_rs1_data;
    assign mprf2crypt_rs2_data = crypt2mprf_rs2_addr == 5'd0 ? 32'd0 : mprf2port_rs2_data;
    assign port2idu_hazard     = (crypt2mprf_rs1_addr != 5'd0 && hit1) ||
                                 (crypt2mprf_rs2_addr != 5'd0 && hit2);
`endif
endmodule
